// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 raster timing constants and helpers
//
// Purpose: shared coordinate type, the default 640x480@60 timing constants, and
// helpers that derive totals and sync window bounds from visible/porch/sync
// widths. Both the generator's defaults and its derived constants come from here.
// Ports: none (package).
`timescale 1ns/1ps
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  function automatic int span_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  // Sync window is [start, end): it begins right after the front porch.
  function automatic int sync_start(input int vis, input int fp);
    return vis + fp;
  endfunction

  function automatic int sync_end(input int vis, input int fp, input int sync);
    return vis + fp + sync;
  endfunction

  localparam int H_TOTAL  = span_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL  = span_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int HS_START = sync_start(DEF_H_VISIBLE, DEF_H_FP);
  localparam int HS_END   = sync_end(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC);
  localparam int VS_START = sync_start(DEF_V_VISIBLE, DEF_V_FP);
  localparam int VS_END   = sync_end(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth shift register with asynchronous reset
//
// Purpose: delays a WIDTH-bit word by DEPTH clock cycles. DEPTH=0 is a plain
// combinational pass-through. Every stage resets to RESET_VAL.
// Ports:
//   clk_i  in   clock
//   rst_i  in   asynchronous active-high reset
//   d_i    in   WIDTH  word entering the line
//   q_o    out  WIDTH  word leaving the line, DEPTH cycles later
`timescale 1ns/1ps
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    // Clock and reset have no job here; fold them into a sink.
    logic unused_pass;
    assign unused_pass = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, sync/blank generation with aligned delays
//
// Purpose: pixel-timing generator feeding the sprite/colour stage. DrawX/DrawY
// address the sprite ROM undelayed; blank and hs/vs leave through delay lines so
// they reach the pins aligned with the colour path (ROM latency + colour reg).
// Ports:
//   vga_clk      in   pixel clock
//   reset        in   asynchronous active-high reset
//   DrawX        out  10    horizontal counter hc
//   DrawY        out  10    vertical counter vc
//   blank        out  1     1 = visible pixel, BLANK_DELAY cycles late
//   hs, vs       out  1     syncs at level SYNC_ACTIVE, SYNC_DELAY cycles late
//   line_start   out  1     high while hc==0
//   frame_start  out  1     high while hc==0 && vc==0
//   frame_count  out  FC_W  completed frames, wrapping
`timescale 1ns/1ps
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int BLANK_DELAY = 1,
  parameter int SYNC_DELAY  = 2,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int FC_W        = 16
) (
  input  logic            vga_clk,
  input  logic            reset,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            blank,
  output logic            hs,
  output logic            vs,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOT = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  if (H_TOT > 1024) begin : g_h_total_check
    $error("vga_timing_gen: horizontal total exceeds 10-bit counter range");
  end
  if (V_TOT > 1024) begin : g_v_total_check
    $error("vga_timing_gen: vertical total exceeds 10-bit counter range");
  end

  localparam coord_t H_LAST = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST = coord_t'(V_TOT - 1);

  // Window bounds are 11 bits so an end bound equal to 1024 does not wrap to 0.
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] HS_LO     = 11'(sync_start(H_VISIBLE, H_FP));
  localparam logic [10:0] HS_HI     = 11'(sync_end(H_VISIBLE, H_FP, H_SYNC));
  localparam logic [10:0] VS_LO     = 11'(sync_start(V_VISIBLE, V_FP));
  localparam logic [10:0] VS_HI     = 11'(sync_end(V_VISIBLE, V_FP, V_SYNC));

  coord_t          hc_q, hc_d;
  coord_t          vc_q, vc_d;
  logic [FC_W-1:0] fc_q, fc_d;

  logic       h_last, v_last;
  logic       vis_raw, hs_raw, vs_raw;
  logic       blank_dl;
  logic [1:0] sync_dl;

  always_comb begin
    h_last = (hc_q == H_LAST);
    v_last = (vc_q == V_LAST);
    hc_d   = hc_q + coord_t'(1);
    vc_d   = vc_q;
    fc_d   = fc_q;
    if (h_last) begin
      hc_d = '0;
      vc_d = v_last ? '0 : vc_q + coord_t'(1);
      if (v_last) begin
        fc_d = fc_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
      fc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      fc_q <= fc_d;
    end
  end

  always_comb begin
    vis_raw = ({1'b0, hc_q} < H_VIS_END) && ({1'b0, vc_q} < V_VIS_END);
    hs_raw  = ({1'b0, hc_q} >= HS_LO) && ({1'b0, hc_q} < HS_HI);
    vs_raw  = ({1'b0, vc_q} >= VS_LO) && ({1'b0, vc_q} < VS_HI);
  end

  vga_delay_line #(
    .WIDTH     (1),
    .DEPTH     (BLANK_DELAY),
    .RESET_VAL (1'b0)
  ) u_blank_dl (
    .clk_i (vga_clk),
    .rst_i (reset),
    .d_i   (vis_raw),
    .q_o   (blank_dl)
  );

  // Syncs travel active-high through the line; polarity is applied at the
  // output so a cleared stage always means "sync inactive".
  vga_delay_line #(
    .WIDTH     (2),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (2'b00)
  ) u_sync_dl (
    .clk_i (vga_clk),
    .rst_i (reset),
    .d_i   ({hs_raw, vs_raw}),
    .q_o   (sync_dl)
  );

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_dl;
  assign hs          = sync_dl[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vs          = sync_dl[0] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign line_start  = (hc_q == '0);
  assign frame_start = (hc_q == '0) && (vc_q == '0);
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (small and full timing)
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
    logic        chk;
    logic        colv;
    logic [9:0]  col;
  } obs_t;

  typedef struct {
    int hv, hf, hsw, hb, vv, vf, vsw, vb, bd, sd, fcw;
  } tcfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s = 1'b1;
  logic rst_f = 1'b1;

  logic [9:0]  x_s, y_s, x_f, y_f;
  logic        blank_s, hs_s, vs_s, ls_s, fs_s;
  logic        blank_f, hs_f, vs_f, ls_f, fs_f;
  logic [1:0]  fc_s;
  logic [15:0] fc_f;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BLANK_DELAY(1), .SYNC_DELAY(2), .SYNC_ACTIVE(1'b0), .FC_W(2)
  ) dut_s (
    .vga_clk(clk), .reset(rst_s), .DrawX(x_s), .DrawY(y_s), .blank(blank_s),
    .hs(hs_s), .vs(vs_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  vga_timing_gen dut_f (
    .vga_clk(clk), .reset(rst_f), .DrawX(x_f), .DrawY(y_f), .blank(blank_f),
    .hs(hs_f), .vs(vs_f), .line_start(ls_f), .frame_start(fs_f), .frame_count(fc_f)
  );

  // Downstream colour path: 1-cycle ROM (data = DrawX) plus output register,
  // and blank pushed through one more stage to line up with it.
  logic [9:0] rom_s, col_s, rom_f, col_f;
  logic       bl1_s, bl1_f;
  always @(posedge clk) begin
    rom_s <= x_s;  col_s <= rom_s;  bl1_s <= blank_s;
    rom_f <= x_f;  col_f <= rom_f;  bl1_f <= blank_f;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   run   = 1'b0;
  obs_t q_s[$];
  obs_t q_f[$];

  function automatic int tot_h(tcfg_t c);
    return c.hv + c.hf + c.hsw + c.hb;
  endfunction

  function automatic int tot_v(tcfg_t c);
    return c.vv + c.vf + c.vsw + c.vb;
  endfunction

  // m = pixel clocks elapsed since the raster was at (0,0).
  function automatic bit vis_at(tcfg_t c, int m);
    int ht = tot_h(c);
    int p  = m % (ht * tot_v(c));
    return ((p % ht) < c.hv) && ((p / ht) < c.vv);
  endfunction

  function automatic bit hs_at(tcfg_t c, int m);
    int x = m % tot_h(c);
    return (x >= c.hv + c.hf) && (x < c.hv + c.hf + c.hsw);
  endfunction

  function automatic bit vs_at(tcfg_t c, int m);
    int ht = tot_h(c);
    int y  = (m % (ht * tot_v(c))) / ht;
    return (y >= c.vv + c.vf) && (y < c.vv + c.vf + c.vsw);
  endfunction

  // Expected observation n clocks after reset release (n=0 also covers "in reset").
  function automatic obs_t model(tcfg_t c, int n);
    obs_t e;
    int ht = tot_h(c);
    int fr = ht * tot_v(c);
    int p  = n % fr;
    e       = '0;
    e.x     = 10'(p % ht);
    e.y     = 10'(p / ht);
    e.ls    = (p % ht) == 0;
    e.fs    = (p == 0);
    e.fc    = 16'((n / fr) % (1 << c.fcw));
    e.blank = (n >= c.bd) && vis_at(c, n - c.bd);
    e.hs    = !((n >= c.sd) && hs_at(c, n - c.sd));
    e.vs    = !((n >= c.sd) && vs_at(c, n - c.sd));
    e.chk   = (n >= 2);
    if (n >= 2) begin
      e.colv = vis_at(c, n - 2);
      e.col  = 10'((n - 2) % ht);
    end
    return e;
  endfunction

  task automatic compare(input string tag, input int idx, input obs_t e, input obs_t a);
    bit ok;
    ok = (a.x == e.x) && (a.y == e.y) && (a.blank == e.blank) && (a.hs == e.hs) &&
         (a.vs == e.vs) && (a.ls == e.ls) && (a.fs == e.fs) && (a.fc == e.fc);
    if (e.chk) ok = ok && (a.colv == e.colv) && (!e.colv || (a.col == e.col));
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s sample=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d colv=%b col=%0d want x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d colv=%b col=%0d",
               tag, idx, a.x, a.y, a.blank, a.hs, a.vs, a.ls, a.fs, a.fc, a.colv, a.col,
               e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs, e.fc, e.colv, e.col);
    end
  endtask

  always @(negedge clk) begin : mon_s
    obs_t e, a;
    int   idx;
    if (run) begin
      if (q_s.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL small_queue_empty sample=%0d got 0 entries want 1", idx);
      end else begin
        e = q_s.pop_front();
        a = '0;
        a.x = x_s; a.y = y_s; a.blank = blank_s; a.hs = hs_s; a.vs = vs_s;
        a.ls = ls_s; a.fs = fs_s; a.fc = 16'(fc_s); a.colv = bl1_s; a.col = col_s;
        compare("small", idx, e, a);
      end
      idx++;
    end
  end

  always @(negedge clk) begin : mon_f
    obs_t e, a;
    int   idx;
    if (run) begin
      if (q_f.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL full_queue_empty sample=%0d got 0 entries want 1", idx);
      end else begin
        e = q_f.pop_front();
        a = '0;
        a.x = x_f; a.y = y_f; a.blank = blank_f; a.hs = hs_f; a.vs = vs_f;
        a.ls = ls_f; a.fs = fs_f; a.fc = fc_f; a.colv = bl1_f; a.col = col_f;
        compare("full", idx, e, a);
      end
      idx++;
    end
  end

  initial begin : stim
    tcfg_t cfg_s, cfg_f;
    int    ns, nf, hold_s;
    bit    fired;
    cfg_s = '{hv:8, hf:1, hsw:2, hb:1, vv:4, vf:1, vsw:1, vb:1, bd:1, sd:2, fcw:2};
    cfg_f = '{hv:640, hf:16, hsw:96, hb:48, vv:480, vf:10, vsw:2, vb:33, bd:1, sd:2, fcw:16};
    ns = 0; nf = 0; hold_s = 0; fired = 1'b0;
    run = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1;
      if (!rst_s) ns++;
      if (!rst_f) nf++;
      rst_f = (cyc < 5);
      if (cyc < 5) begin
        rst_s = 1'b1;
      end else if (hold_s > 0) begin
        rst_s = 1'b1;
        hold_s--;
      end else if (!rst_s && !fired && ns == 5 * 84 + 71) begin
        // Lands on (vc,hc)=(5,11): delayed hs and vs are both asserted here.
        rst_s  = 1'b1;
        hold_s = 2;
        fired  = 1'b1;
      end else if (cyc > 1200 && $urandom_range(0, 149) == 0) begin
        rst_s  = 1'b1;
        hold_s = $urandom_range(0, 2);
      end else begin
        rst_s = 1'b0;
      end
      if (rst_s) ns = 0;
      if (rst_f) nf = 0;
      q_s.push_back(model(cfg_s, ns));
      q_f.push_back(model(cfg_f, nf));
    end
    @(posedge clk);
    #1;
    run = 1'b0;
    if (q_s.size() != 0 || q_f.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d/%0d left want 0/0", q_s.size(), q_f.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
